// File: rtl/branch_predict_unit_pkg.sv
// Shared types and constants for the branch predictor: stall bus layout,
// instruction address width and 2-bit direction counter encodings.
package branch_predict_unit_pkg;

  localparam int STALL_W      = 6;   // Stall_size (5:0)
  localparam int EX_HOLD      = 4;   // stall bit that holds EX in place
  localparam int INSTR_ADDR_W = 32;  // Instruction_Address_size

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline <-> branch predictor bus: ID lookup side, EX resolve side,
// flush/redirect back to the pipeline and the statistics counters.
interface branch_predict_unit_if
  import branch_predict_unit_pkg::*;
#(
  parameter int PC_W = INSTR_ADDR_W
);

  logic [PC_W-1:0]    id_pc;
  logic               id_is_branch;
  logic               id_pred_taken;
  logic [STALL_W-1:0] stall_state;
  logic               ex_valid;
  logic [PC_W-1:0]    ex_pc;
  logic               ex_prediction;
  logic               ex_taken;
  logic [PC_W-1:0]    ex_target;
  logic               discard;
  logic [PC_W-1:0]    redirect_pc;
  logic [31:0]        br_count;
  logic [31:0]        miss_count;

  modport master (
    output id_pc, id_is_branch, stall_state, ex_valid, ex_pc,
           ex_prediction, ex_taken, ex_target,
    input  id_pred_taken, discard, redirect_pc, br_count, miss_count
  );

  modport slave (
    input  id_pc, id_is_branch, stall_state, ex_valid, ex_pc,
           ex_prediction, ex_taken, ex_target,
    output id_pred_taken, discard, redirect_pc, br_count, miss_count
  );

endinterface

// File: rtl/branch_predict_unit_sat_counter2.sv
// Pure next-state function of a 2-bit saturating direction counter.
module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = ctr_t'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direction predictor: 2-bit counter table looked up from ID, trained from EX.
// Optional macro BP_GSHARE_EN hashes the committed global history into the index.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int PC_W  = INSTR_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  branch_predict_unit_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       ctr_tab [ENTRIES];
  logic [GHR_W-1:0] ghr;
  logic [31:0]      br_cnt;
  logic [31:0]      miss_cnt;

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic             fire;
  logic             mispredict;
  logic             discard;
  ctr_t             upd_cur;
  ctr_t             upd_next;
  logic             unused_bits;

`ifdef BP_GSHARE_EN
  // Both sides hash with the ghr of the current cycle; update sees pre-shift history.
  assign lookup_idx = bus.id_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  assign update_idx = bus.ex_pc[IDX_W+1:2] ^ IDX_W'(ghr);
`else
  assign lookup_idx = bus.id_pc[IDX_W+1:2];
  assign update_idx = bus.ex_pc[IDX_W+1:2];
`endif

  // Combinational read of the registered table: a same-cycle write is not visible yet.
  assign bus.id_pred_taken = bus.id_is_branch & ctr_tab[lookup_idx][1];

  assign fire       = bus.ex_valid & ~bus.stall_state[EX_HOLD] & rst;
  assign mispredict = bus.ex_valid & (bus.ex_taken != bus.ex_prediction);
  // Stays asserted while EX is held so the flush is stable until the branch leaves.
  assign discard    = mispredict & rst;

  assign bus.discard     = discard;
  assign bus.redirect_pc = !discard     ? '0 :
                           bus.ex_taken ? bus.ex_target :
                                          bus.ex_pc + PC_W'(4);
  assign bus.br_count    = br_cnt;
  assign bus.miss_count  = miss_cnt;

  assign upd_cur = ctr_t'(ctr_tab[update_idx]);

  sat_counter2 u_sat (
    .cur   (upd_cur),
    .taken (bus.ex_taken),
    .nxt   (upd_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_tab[i] <= WNT;
      ghr      <= '0;
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (fire) begin
      ctr_tab[update_idx] <= upd_next;
      ghr                 <= GHR_W'({ghr, bus.ex_taken});
      br_cnt              <= br_cnt + 32'd1;
      if (mispredict) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign unused_bits = ^{bus.id_pc[PC_W-1:IDX_W+2], bus.id_pc[1:0],
                         bus.stall_state[STALL_W-1:EX_HOLD+1],
                         bus.stall_state[EX_HOLD-1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized self-checking bench for branch_predict_unit against a
// behavioural predictor model (bimodal or gshare following BP_GSHARE_EN).
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  localparam int IDX_W = 6;
  localparam int GHR_W = 6;
  localparam int PC_W  = 32;
  localparam int N     = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(PC_W)) bus ();

  branch_predict_unit #(.IDX_W(IDX_W), .GHR_W(GHR_W), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_ctr [N];
  int m_ghr;
  int m_br;
  int m_miss;

  function automatic int m_idx(input logic [PC_W-1:0] pc);
    int i;
    i = int'((pc >> 2) & 32'(N - 1));
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic logic m_pred(input logic [PC_W-1:0] pc);
    return m_ctr[m_idx(pc)] >= 2;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_ctr[i] = 1;
    m_ghr  = 0;
    m_br   = 0;
    m_miss = 0;
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic pred,
                       input logic tk, input logic [PC_W-1:0] tgt, input logic [5:0] st);
    bus.ex_valid      = v;
    bus.ex_pc         = pc;
    bus.ex_prediction = pred;
    bus.ex_taken      = tk;
    bus.ex_target     = tgt;
    bus.stall_state   = st;
  endtask

  // Commit the model for this cycle (if the branch fires), then advance one clock.
  task automatic tick();
    if (bus.ex_valid && !bus.stall_state[4] && rst) begin
      int i;
      i = m_idx(bus.ex_pc);
      if (bus.ex_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else              m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      m_br++;
      if (bus.ex_taken != bus.ex_prediction) m_miss++;
      m_ghr = ((m_ghr << 1) | int'(bus.ex_taken)) % (1 << GHR_W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    bus.id_pc        = 32'h100;
    bus.id_is_branch = 1'b1;
    drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h400, 6'd0);
    #2;
    total++; if (bus.discard !== 1'b0) begin bad++; $display("FAIL reset_discard: got %0b want 0", bus.discard); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect: got %0h want 0", bus.redirect_pc); end
    total++; if (bus.id_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred: got %0b want 0", bus.id_pred_taken); end
    tick();
    tick();
    total++; if (bus.br_count !== 32'd0) begin bad++; $display("FAIL reset_br_count: got %0d want 0", bus.br_count); end
    total++; if (bus.miss_count !== 32'd0) begin bad++; $display("FAIL reset_miss_count: got %0d want 0", bus.miss_count); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd0);
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_train_taken();
    for (int k = 0; k < 2; k++) begin
      logic exp_pred;
      bus.id_pc = 32'h100;
      drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h400, 6'd0);
      #1;
      exp_pred = m_pred(32'h100);
      total++; if (bus.id_pred_taken !== exp_pred) begin bad++; $display("FAIL train_pred: got %0b want %0b", bus.id_pred_taken, exp_pred); end
      total++; if (bus.discard !== 1'b1) begin bad++; $display("FAIL train_discard: got %0b want 1", bus.discard); end
      total++; if (bus.redirect_pc !== 32'h400) begin bad++; $display("FAIL train_redirect: got %0h want 400", bus.redirect_pc); end
      tick();
    end
`ifndef BP_GSHARE_EN
    total++; if (bus.id_pred_taken !== 1'b1) begin bad++; $display("FAIL train_pred_after: got %0b want 1", bus.id_pred_taken); end
`endif
    total++; if (bus.miss_count !== 32'd2) begin bad++; $display("FAIL train_miss_count: got %0d want 2", bus.miss_count); end
    total++; if (bus.br_count !== 32'd2) begin bad++; $display("FAIL train_br_count: got %0d want 2", bus.br_count); end
  endtask

  task automatic test_not_taken();
    drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h12345678, 6'd0);
    #1;
    total++; if (bus.discard !== 1'b1) begin bad++; $display("FAIL nt_discard: got %0b want 1", bus.discard); end
    total++; if (bus.redirect_pc !== 32'h204) begin bad++; $display("FAIL nt_redirect: got %0h want 204", bus.redirect_pc); end
    tick();
    total++; if (bus.miss_count !== 32'(m_miss)) begin bad++; $display("FAIL nt_miss_count: got %0d want %0d", bus.miss_count, m_miss); end
    drive(1'b1, 32'h208, 1'b1, 1'b1, 32'h7000, 6'd0);
    #1;
    total++; if (bus.discard !== 1'b0 || bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL correct_pred: got discard=%0b pc=%0h want 0/0", bus.discard, bus.redirect_pc); end
    tick();
  endtask

  task automatic test_stall_hold();
    int saved;
    saved = m_br;
    drive(1'b1, 32'h44, 1'b0, 1'b1, 32'h800, 6'b010000);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (bus.discard !== 1'b1) begin bad++; $display("FAIL stall_discard: got %0b want 1", bus.discard); end
      total++; if (bus.br_count !== 32'(saved)) begin bad++; $display("FAIL stall_br_count: got %0d want %0d", bus.br_count, saved); end
      tick();
    end
    bus.stall_state = 6'b101111;
    #1;
    total++; if (bus.discard !== 1'b1) begin bad++; $display("FAIL stall_release_discard: got %0b want 1", bus.discard); end
    tick();
    total++; if (bus.br_count !== 32'(saved + 1)) begin bad++; $display("FAIL stall_release_count: got %0d want %0d", bus.br_count, saved + 1); end
    drive(1'b0, 32'h44, 1'b0, 1'b1, 32'h800, 6'd0);
    tick();
    total++; if (bus.br_count !== 32'(saved + 1)) begin bad++; $display("FAIL stall_once: got %0d want %0d", bus.br_count, saved + 1); end
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 8; k++) begin
      logic exp_old, exp_new;
      bus.id_pc = 32'h1C;
      drive(1'b1, 32'h1C, m_pred(32'h1C), (k < 4), 32'h500, 6'd0);
      #1;
      exp_old = m_pred(32'h1C);
      total++; if (bus.id_pred_taken !== exp_old) begin bad++; $display("FAIL same_old: got %0b want %0b", bus.id_pred_taken, exp_old); end
      tick();
      exp_new = m_pred(32'h1C);
      total++; if (bus.id_pred_taken !== exp_new) begin bad++; $display("FAIL same_new: got %0b want %0b", bus.id_pred_taken, exp_new); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [PC_W-1:0] epc, ipc, tgt, exp_rd;
      logic [5:0] st;
      logic v, tk, pr, exp_disc, exp_pred;
      epc = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 19) == 0) epc = 32'hFFFF_FFFC;
      ipc = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 31)) << 2);
      tgt = $urandom;
      v   = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1) == 1;
      pr  = ($urandom_range(0, 1) == 1) ? m_pred(epc) : ($urandom_range(0, 1) == 1);
      st  = 6'($urandom);
      st[4] = ($urandom_range(0, 3) == 0);
      bus.id_pc        = ipc;
      bus.id_is_branch = 1'b1;
      drive(v, epc, pr, tk, tgt, st);
      #1;
      exp_pred = m_pred(ipc);
      exp_disc = v && (tk != pr);
      exp_rd   = !exp_disc ? 32'h0 : (tk ? tgt : epc + 32'd4);
      total++; if (bus.id_pred_taken !== exp_pred) begin bad++; $display("FAIL rand_pred: got %0b want %0b", bus.id_pred_taken, exp_pred); end
      total++; if (bus.discard !== exp_disc) begin bad++; $display("FAIL rand_discard: got %0b want %0b", bus.discard, exp_disc); end
      total++; if (bus.redirect_pc !== exp_rd) begin bad++; $display("FAIL rand_redirect: got %0h want %0h", bus.redirect_pc, exp_rd); end
      tick();
      total++; if (bus.br_count !== 32'(m_br)) begin bad++; $display("FAIL rand_br_count: got %0d want %0d", bus.br_count, m_br); end
      total++; if (bus.miss_count !== 32'(m_miss)) begin bad++; $display("FAIL rand_miss_count: got %0d want %0d", bus.miss_count, m_miss); end
    end
  endtask

  task automatic test_reset_mid();
    bus.id_pc = 32'h100;
    drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h400, 6'b010000);
    #1 rst = 1'b0;
    #1;
    m_reset();
    total++; if (bus.discard !== 1'b0) begin bad++; $display("FAIL midrst_discard: got %0b want 0", bus.discard); end
    total++; if (bus.br_count !== 32'd0 || bus.miss_count !== 32'd0) begin bad++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", bus.br_count, bus.miss_count); end
    total++; if (bus.id_pred_taken !== 1'b0) begin bad++; $display("FAIL midrst_pred: got %0b want 0", bus.id_pred_taken); end
    #3 rst = 1'b1;
    tick();
    tick();
    drive(1'b0, 32'h100, 1'b0, 1'b1, 32'h400, 6'd0);
    tick();
    total++; if (bus.br_count !== 32'd0) begin bad++; $display("FAIL midrst_not_counted: got %0d want 0", bus.br_count); end
  endtask

  task automatic test_alternating();
    logic [31:0] start;
    start = 32'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    m_reset();
    for (int k = 0; k < 40; k++) begin
      logic tk, pr;
      tk = (k % 2) == 0;
      pr = m_pred(32'h40);
      bus.id_pc = 32'h40;
      drive(1'b1, 32'h40, pr, tk, 32'h900, 6'd0);
      #1;
      if (k == 20) start = bus.miss_count;
      total++; if (bus.id_pred_taken !== pr) begin bad++; $display("FAIL alt_pred: got %0b want %0b", bus.id_pred_taken, pr); end
      total++; if (bus.discard !== (tk != pr)) begin bad++; $display("FAIL alt_discard: got %0b want %0b", bus.discard, tk != pr); end
      tick();
    end
`ifdef BP_GSHARE_EN
    total++; if (bus.miss_count - start !== 32'd0) begin bad++; $display("FAIL alt_late_misses: got %0d want 0", bus.miss_count - start); end
`else
    total++; if (bus.miss_count - start !== 32'd20) begin bad++; $display("FAIL alt_late_misses: got %0d want 20", bus.miss_count - start); end
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd0);
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_not_taken();
    test_stall_hold();
    test_same_cycle();
    test_random();
    test_reset_mid();
    test_alternating();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
